// File: rtl/tcdm_stream_reader.sv
// Strided TCDM word reader that streams the returned words through a response FIFO.
// Optional performance counters are built when TCDM_STREAM_READER_PERF_EN is defined.
module tcdm_stream_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [31:0]      base_addr_i,
  input  logic [31:0]      stride_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             tcdm_req_o,
  output logic [31:0]      tcdm_add_o,
  output logic             tcdm_wen_o,
  output logic [3:0]       tcdm_be_o,
  output logic [31:0]      tcdm_data_o,
  input  logic             tcdm_gnt_i,
  input  logic [31:0]      tcdm_r_data_i,
  input  logic             tcdm_r_valid_i,
  output logic             stream_valid_o,
  input  logic             stream_ready_i,
  output logic [31:0]      stream_data_o,
  output logic             stream_last_o,
  output logic [31:0]      perf_cycles_o,
  output logic [31:0]      perf_stalls_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic [31:0]      stride_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] last_idx;
  logic [LEN_W-1:0] issue_idx;
  logic [LEN_W-1:0] pop_idx;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   inflight;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      mem [FIFO_DEPTH];
  logic             done_zero;

  logic active;
  logic abort;
  logic grant;
  logic rsp;
  logic push;
  logic pop;
  logic last_pop;

  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = 4'hF;
  assign tcdm_data_o = '0;
  assign tcdm_add_o  = addr_q;

  assign busy_o   = (state != IDLE);
  assign active   = (state == ISSUE) || (state == WAIT);
  assign abort    = active && clear_i;
  assign last_idx = len_q - LEN_W'(1);

  // Requests and buffered words together never exceed the FIFO, so responses need no back-pressure.
  assign inflight   = {1'b0, outstanding} + {1'b0, occupancy};
  assign tcdm_req_o = (state == ISSUE) && !clear_i && (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign grant      = tcdm_req_o && tcdm_gnt_i;

  // Responses with nothing outstanding are stray and ignored; in DRAIN they only retire the count.
  assign rsp  = tcdm_r_valid_i && (outstanding != '0);
  assign push = rsp && active && !clear_i;

  assign stream_valid_o = active && (occupancy != '0);
  assign stream_data_o  = stream_valid_o ? mem[rd_ptr] : '0;
  assign stream_last_o  = stream_valid_o && (pop_idx == last_idx);
  assign pop            = stream_valid_o && stream_ready_i;

  assign last_pop = pop && (state == WAIT) && (pop_idx == last_idx);
  assign done_o   = done_zero || (last_pop && !clear_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      len_q       <= '0;
      issue_idx   <= '0;
      pop_idx     <= '0;
      outstanding <= '0;
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      done_zero   <= 1'b0;
    end else begin
      done_zero   <= 1'b0;
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp);

      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              state     <= ISSUE;
              addr_q    <= base_addr_i;
              stride_q  <= stride_i;
              len_q     <= len_i;
              issue_idx <= '0;
              pop_idx   <= '0;
            end else begin
              done_zero <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (clear_i)                             state <= DRAIN;
          else if (grant && issue_idx == last_idx) state <= WAIT;
        end
        WAIT: begin
          if (clear_i)       state <= DRAIN;
          else if (last_pop) state <= IDLE;
        end
        DRAIN: begin
          if (outstanding == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (grant) begin
        addr_q    <= addr_q + stride_q;
        issue_idx <= issue_idx + LEN_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        pop_idx <= pop_idx + LEN_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      if (abort) begin
        occupancy <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage is data only: the output mux hides stale contents, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= tcdm_r_data_i;
  end

`ifdef TCDM_STREAM_READER_PERF_EN
  logic [31:0] cycles_q;
  logic [31:0] stalls_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycles_q <= '0;
      stalls_q <= '0;
    end else if (state == IDLE && start_i) begin
      cycles_q <= '0;
      stalls_q <= '0;
    end else begin
      if (busy_o)                   cycles_q <= sat_inc(cycles_q);
      if (tcdm_req_o && !tcdm_gnt_i) stalls_q <= sat_inc(stalls_q);
    end
  end

  assign perf_cycles_o = cycles_q;
  assign perf_stalls_o = stalls_q;
`else
  assign perf_cycles_o = '0;
  assign perf_stalls_o = '0;
`endif

endmodule
